reflet_mem_bridge: RTL and testbench
====================================

// Module: reflet_mem_bridge
// PURPOSE
//  Sits between the CPU RAM port (addr/data_out/data_in/write_en) and an external req/ack memory bus.
//  Holds one cached, word-aligned read word and serves the CPU from it; misses and writes go out as bus transactions.
//  Freezes the CPU through cpu_enable while a transaction is pending, so RAM latency is invisible to the CPU.
//  Writes are write-through.
// PARAMETERS
//  wordsize  16   data/address width in bits; multiple of 8, >= 8
//  TIMEOUT   255  max cycles waiting for bus_ack (used only with REFLET_BRIDGE_TIMEOUT_EN); >= 1
// PORTS
//  clk           in   1    clock, rising edge
//  reset         in   1    synchronous, active-low
//  enable_in     in   1    global enable from the system
//  cpu_addr      in   W    byte address from CPU
//  cpu_data_out  in   W    write data from CPU
//  cpu_write_en  in   1    CPU write strobe; held while CPU is frozen
//  cpu_data_in   out  W    read data to CPU (cached word)
//  cpu_enable    out  1    enable for the CPU; combinational
//  bus_addr      out  W    word-aligned address: cpu_addr with low log2(W/8) bits zeroed
//  bus_wdata     out  W    bus write data
//  bus_we        out  1    1 = write, 0 = read; qualified by bus_req
//  bus_req       out  1    transaction request
//  bus_ack       in   1    transaction complete; bus_rdata valid in the same cycle for reads
//  bus_rdata     in   W    bus read data
//  bus_error     out  1    one-cycle timeout pulse (TIMEOUT_EN only, else 0)
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - state=IDLE, valid=0, tag=0, data=0, wr_done=0
//   - bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_error=0
//   - A transaction in flight is abandoned and bus_req drops next cycle; the slave must tolerate this.
//  hit = valid && (aligned cpu_addr == tag). cpu_data_in = data (registered) at all times.
//  cpu_enable = enable_in && state==IDLE && hit && (!cpu_write_en || wr_done)
//  FSM (runs regardless of enable_in):
//   - IDLE:
//     - cpu_write_en && !wr_done -> latch aligned addr and cpu_data_out; bus_we=1, bus_req=1 -> WRITE
//     - else !hit -> latch aligned addr; bus_we=0, bus_req=1 -> READ
//     - Write has priority over miss.
//   - READ:  hold bus_* stable. On bus_ack: tag<=addr, data<=bus_rdata, valid<=1, bus_req<=0 -> IDLE.
//   - WRITE: hold bus_* stable. On bus_ack: bus_req<=0, wr_done<=1.
//       If tag==addr, also data<=wdata. valid is not set on a write miss (no write-allocate). -> IDLE.
//   - wr_done clears on the first cycle with cpu_enable==1. This lets the CPU retire its write strobe exactly once.
//  Latency:
//   - Hit: 0 stall cycles.
//   - Miss/write: CPU frozen from detection until 1 cycle after the cycle bus_ack is sampled.
//     With ack in the cycle after req, the freeze is 2 cycles.
//  Bus rules:
//   - bus_req rises only from IDLE and stays high until bus_ack is sampled.
//   - bus_addr, bus_we and bus_wdata are constant while bus_req is high.
//   - bus_ack while bus_req==0 is ignored.
//   - At most one outstanding transaction.
//  Address: low log2(W/8) bits never leave the block; byte lanes are handled upstream.
//   For W==8 no bits are dropped.
// CONFIGURATION
//  REFLET_BRIDGE_TIMEOUT_EN defined:
//   - Counter, width clog2(TIMEOUT+1), cleared on entry to READ/WRITE, +1 per cycle without ack.
//   - When the count reaches TIMEOUT: bus_req<=0, bus_error pulses 1 cycle, state -> IDLE.
//   - Read timeout: tag<=addr, data<=0, valid<=1, so the CPU reads 0 and proceeds.
//   - Write timeout: data is dropped, wr_done<=1, cache is unchanged.
//   - An ack in the same cycle as the limit wins.
//  Not defined: waits for bus_ack indefinitely; bus_error tied 0; no counter logic.
// TESTING
//  - Reset, cpu_addr=0x0004, ack 1 cycle after req, rdata=0xBEEF:
//    read bus_addr=0x0004, cpu_enable 0 for 2 cycles, then cpu_data_in=0xBEEF, enable=1.
//  - Hit then miss: read 0x0004 twice -> one bus read only. cpu_addr=0x0005 (W=16) -> still a hit, no bus read.
//    cpu_addr=0x0006 -> new bus read.
//  - Write hit: cached 0x0004, cpu_write_en=1, data 0x1234 ->
//    one bus write (we=1, addr 0x0004, wdata 0x1234), cpu_data_in=0x1234 after, exactly one bus_req pulse.
//  - Slave delays ack by 5 cycles with enable_in toggling -> bus_* stable throughout, cpu_enable never 1 before ack+1.
//  - Reset low during READ -> next cycle bus_req=0, valid=0; after release, same address re-read.
//  - TIMEOUT_EN, TIMEOUT=4, no ack -> bus_error 1-cycle pulse 4 cycles after req, cpu_data_in=0, CPU resumes.

Source files
------------

// File: rtl/reflet_mem_bridge_if.sv
// Request/acknowledge memory bus between reflet_mem_bridge (master) and external RAM (slave).
interface reflet_mem_bridge_if #(
  parameter int W = 16
) ();
  logic [W-1:0] bus_addr;
  logic [W-1:0] bus_wdata;
  logic         bus_we;
  logic         bus_req;
  logic         bus_ack;
  logic [W-1:0] bus_rdata;
  logic         bus_error;

  modport master (
    output bus_addr, bus_wdata, bus_we, bus_req, bus_error,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_we, bus_req, bus_error,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/reflet_mem_bridge.sv
// One-word read cache with write-through between the CPU RAM port and a req/ack bus.
// Optional bus timeout enabled with `define REFLET_BRIDGE_TIMEOUT_EN.
module reflet_mem_bridge #(
  parameter int wordsize = 16,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable_in,
  input  logic [wordsize-1:0] cpu_addr,
  input  logic [wordsize-1:0] cpu_data_out,
  input  logic                cpu_write_en,
  output logic [wordsize-1:0] cpu_data_in,
  output logic                cpu_enable,
  reflet_mem_bridge_if.master bus
);

  localparam int LB = (wordsize > 8) ? $clog2(wordsize / 8) : 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  function automatic logic [wordsize-1:0] align_addr(input logic [wordsize-1:0] a);
    align_addr = (a >> LB) << LB;
  endfunction

  state_e              state_q, state_d;
  logic                valid_q, valid_d;
  logic [wordsize-1:0] tag_q, tag_d;
  logic [wordsize-1:0] data_q, data_d;
  logic                wr_done_q, wr_done_d;
  logic [wordsize-1:0] addr_q, addr_d;
  logic [wordsize-1:0] wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                req_q, req_d;
  logic [wordsize-1:0] aligned_s;
  logic                hit_s;

`ifdef REFLET_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          error_q, error_d;
`endif

  assign aligned_s   = align_addr(cpu_addr);
  assign hit_s       = valid_q && (aligned_s == tag_q);
  assign cpu_data_in = data_q;
  assign cpu_enable  = enable_in && (state_q == ST_IDLE) && hit_s && (!cpu_write_en || wr_done_q);

  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_req   = req_q;
`ifdef REFLET_BRIDGE_TIMEOUT_EN
  assign bus.bus_error = error_q;
`else
  assign bus.bus_error = 1'b0;
`endif

  // State and cache registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      tag_q     <= '0;
      data_q    <= '0;
      wr_done_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      req_q     <= 1'b0;
`ifdef REFLET_BRIDGE_TIMEOUT_EN
      cnt_q     <= '0;
      error_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      data_q    <= data_d;
      wr_done_q <= wr_done_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      req_q     <= req_d;
`ifdef REFLET_BRIDGE_TIMEOUT_EN
      cnt_q     <= cnt_d;
      error_q   <= error_d;
`endif
    end
  end

  // Next-state logic: bus fields are only loaded in IDLE so they stay stable while req is high.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    tag_d     = tag_q;
    data_d    = data_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    req_d     = req_q;
`ifdef REFLET_BRIDGE_TIMEOUT_EN
    cnt_d     = cnt_q;
    error_d   = 1'b0;
`endif
    // The CPU retires its write strobe on the first enabled cycle after completion.
    if (cpu_enable) begin
      wr_done_d = 1'b0;
    end else begin
      wr_done_d = wr_done_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (cpu_write_en && !wr_done_q) begin
          addr_d  = aligned_s;
          wdata_d = cpu_data_out;
          we_d    = 1'b1;
          req_d   = 1'b1;
          state_d = ST_WRITE;
`ifdef REFLET_BRIDGE_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (!hit_s) begin
          addr_d  = aligned_s;
          we_d    = 1'b0;
          req_d   = 1'b1;
          state_d = ST_READ;
`ifdef REFLET_BRIDGE_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (bus.bus_ack) begin
          tag_d   = addr_q;
          data_d  = bus.bus_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = ST_IDLE;
`ifdef REFLET_BRIDGE_TIMEOUT_EN
        end else if (cnt_q == LIMIT) begin
          // A dead bus reads as zero so the CPU can make progress.
          tag_d   = addr_q;
          data_d  = '0;
          valid_d = 1'b1;
          req_d   = 1'b0;
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
`else
        end else begin
          state_d = ST_READ;
        end
`endif
      end
      ST_WRITE: begin
        if (bus.bus_ack) begin
          req_d     = 1'b0;
          wr_done_d = 1'b1;
          state_d   = ST_IDLE;
          if (tag_q == addr_q) begin
            data_d = wdata_q;
          end else begin
            data_d = data_q;
          end
`ifdef REFLET_BRIDGE_TIMEOUT_EN
        end else if (cnt_q == LIMIT) begin
          req_d     = 1'b0;
          wr_done_d = 1'b1;
          error_d   = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d     = cnt_q + 1'b1;
        end
`else
        end else begin
          state_d = ST_WRITE;
        end
`endif
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_reflet_mem_bridge.sv
// Directed self-checking bench for reflet_mem_bridge with a configurable-latency bus slave.
module tb_reflet_mem_bridge;

`ifdef REFLET_BRIDGE_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        enable_in;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_data_out;
  logic        cpu_write_en;
  logic [15:0] cpu_data_in;
  logic        cpu_enable;

  reflet_mem_bridge_if #(.W(16)) bif ();

  reflet_mem_bridge #(.wordsize(16), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable_in    (enable_in),
    .cpu_addr     (cpu_addr),
    .cpu_data_out (cpu_data_out),
    .cpu_write_en (cpu_write_en),
    .cpu_data_in  (cpu_data_in),
    .cpu_enable   (cpu_enable),
    .bus          (bif.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // slave and bus monitor state
  int          ack_delay = 1;
  logic [15:0] slave_rdata = 16'h0000;
  logic        slv_ack = 1'b0;
  logic [15:0] slv_rdata_q = 16'h0000;
  int          req_cycles = 0;
  int          txn = 0;
  int          rises = 0;
  int          stab_err = 0;
  logic        prev_req = 1'b0;
  logic [15:0] snap_addr = 16'h0000;
  logic [15:0] snap_wdata = 16'h0000;
  logic        snap_we = 1'b0;
  logic [15:0] last_addr = 16'h0000;
  logic [15:0] last_wdata = 16'h0000;
  logic        last_we = 1'b0;

  assign bif.bus_ack   = slv_ack;
  assign bif.bus_rdata = slv_rdata_q;

  // Slave acks on the ack_delay-th cycle of a request (0 = never); monitor checks bus stability.
  always @(negedge clk) begin
    if (bif.bus_req) begin
      if (!prev_req) begin
        rises      <= rises + 1;
        snap_addr  <= bif.bus_addr;
        snap_wdata <= bif.bus_wdata;
        snap_we    <= bif.bus_we;
      end else if (bif.bus_addr !== snap_addr || bif.bus_wdata !== snap_wdata || bif.bus_we !== snap_we) begin
        stab_err <= stab_err + 1;
      end
    end
    prev_req <= bif.bus_req;
    if (bif.bus_req && !slv_ack) begin
      req_cycles <= req_cycles + 1;
      if (ack_delay != 0 && req_cycles + 1 >= ack_delay) begin
        slv_ack     <= 1'b1;
        slv_rdata_q <= slave_rdata;
        txn         <= txn + 1;
        last_addr   <= bif.bus_addr;
        last_wdata  <= bif.bus_wdata;
        last_we     <= bif.bus_we;
      end
    end else begin
      slv_ack    <= 1'b0;
      req_cycles <= 0;
    end
  end

  task automatic run_until_enable(output int stalls);
    stalls = 0;
    #1;
    while (cpu_enable !== 1'b1 && stalls < 60) begin
      stalls++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; enable_in = 1'b1; cpu_addr = 16'h0004;
    cpu_data_out = 16'h0000; cpu_write_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bif.bus_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0h exp=0", bif.bus_req); end
    checks++; if (bif.bus_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%0h exp=0", bif.bus_we); end
    checks++; if (bif.bus_addr !== 16'h0000) begin failures++; $display("FAIL rst_addr got=%h exp=0000", bif.bus_addr); end
    checks++; if (bif.bus_wdata !== 16'h0000) begin failures++; $display("FAIL rst_wdata got=%h exp=0000", bif.bus_wdata); end
    checks++; if (bif.bus_error !== 1'b0) begin failures++; $display("FAIL rst_error got=%0h exp=0", bif.bus_error); end
    checks++; if (cpu_data_in !== 16'h0000) begin failures++; $display("FAIL rst_data got=%h exp=0000", cpu_data_in); end
    checks++; if (cpu_enable !== 1'b0) begin failures++; $display("FAIL rst_enable got=%0h exp=0", cpu_enable); end
  endtask

  task automatic test_read_miss;
    int st, t0;
    @(negedge clk);
    reset = 1'b1; slave_rdata = 16'hBEEF; t0 = txn;
    run_until_enable(st);
    checks++; if (st != 2) begin failures++; $display("FAIL miss_stall got=%0d exp=2", st); end
    checks++; if (cpu_data_in !== 16'hBEEF) begin failures++; $display("FAIL miss_data got=%h exp=beef", cpu_data_in); end
    checks++; if (txn != t0 + 1) begin failures++; $display("FAIL miss_txn got=%0d exp=%0d", txn, t0 + 1); end
    checks++; if (last_addr !== 16'h0004 || last_we !== 1'b0) begin failures++; $display("FAIL miss_bus got=%h/%0h exp=0004/0", last_addr, last_we); end
  endtask

  task automatic test_hit_miss;
    int st, t0;
    t0 = txn;
    @(negedge clk); #1;
    checks++; if (cpu_enable !== 1'b1) begin failures++; $display("FAIL hit_same got=%0h exp=1", cpu_enable); end
    @(negedge clk); cpu_addr = 16'h0005; #1;
    checks++; if (cpu_enable !== 1'b1 || cpu_data_in !== 16'hBEEF) begin failures++; $display("FAIL hit_odd got=%0h/%h exp=1/beef", cpu_enable, cpu_data_in); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (txn != t0) begin failures++; $display("FAIL hit_no_txn got=%0d exp=%0d", txn, t0); end
    @(negedge clk); cpu_addr = 16'h0007; slave_rdata = 16'h5A5A;
    run_until_enable(st);
    checks++; if (st != 2 || cpu_data_in !== 16'h5A5A) begin failures++; $display("FAIL miss2 got=%0d/%h exp=2/5a5a", st, cpu_data_in); end
    checks++; if (last_addr !== 16'h0006 || txn != t0 + 1) begin failures++; $display("FAIL miss2_align got=%h/%0d exp=0006/%0d", last_addr, txn, t0 + 1); end
  endtask

  task automatic test_write_hit;
    int st, r0;
    @(negedge clk); cpu_addr = 16'h0004; slave_rdata = 16'hBEEF;
    run_until_enable(st);
    r0 = rises;
    @(negedge clk); cpu_data_out = 16'h1234; cpu_write_en = 1'b1;
    run_until_enable(st);
    checks++; if (st != 2) begin failures++; $display("FAIL wr_stall got=%0d exp=2", st); end
    @(negedge clk); cpu_write_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (cpu_data_in !== 16'h1234 || cpu_enable !== 1'b1) begin failures++; $display("FAIL wr_data got=%h/%0h exp=1234/1", cpu_data_in, cpu_enable); end
    checks++; if (rises != r0 + 1) begin failures++; $display("FAIL wr_one_req got=%0d exp=%0d", rises, r0 + 1); end
    checks++; if (last_we !== 1'b1 || last_addr !== 16'h0004 || last_wdata !== 16'h1234) begin
      failures++; $display("FAIL wr_bus got=%0h/%h/%h exp=1/0004/1234", last_we, last_addr, last_wdata); end
  endtask

  task automatic test_write_miss;
    int st, t0;
    @(negedge clk); cpu_addr = 16'h0010; cpu_data_out = 16'hAAAA; cpu_write_en = 1'b1;
    slave_rdata = 16'h7777; t0 = txn;
    run_until_enable(st);
    checks++; if (st != 4) begin failures++; $display("FAIL wmiss_stall got=%0d exp=4", st); end
    @(negedge clk); cpu_write_en = 1'b0; #1;
    checks++; if (cpu_data_in !== 16'h7777 || txn != t0 + 2) begin failures++; $display("FAIL wmiss_noalloc got=%h/%0d exp=7777/%0d", cpu_data_in, txn, t0 + 2); end
  endtask

  task automatic test_slow_ack;
    int r0, s0;
    logic exp_en;
    @(negedge clk);
    ack_delay = 5; r0 = rises; s0 = stab_err; cpu_addr = 16'h0020; slave_rdata = 16'h0F0F;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      enable_in = (i % 2 == 0) ? 1'b1 : 1'b0;
      #1;
      exp_en = (i >= 6) ? enable_in : 1'b0;
      checks++; if (cpu_enable !== exp_en) begin failures++; $display("FAIL slow_en cyc=%0d got=%0h exp=%0h", i, cpu_enable, exp_en); end
    end
    @(negedge clk); enable_in = 1'b1; ack_delay = 1; #1;
    checks++; if (stab_err != s0) begin failures++; $display("FAIL slow_stable got=%0d exp=%0d", stab_err, s0); end
    checks++; if (rises != r0 + 1 || last_addr !== 16'h0020) begin failures++; $display("FAIL slow_req got=%0d/%h exp=%0d/0020", rises, last_addr, r0 + 1); end
    checks++; if (cpu_data_in !== 16'h0F0F) begin failures++; $display("FAIL slow_data got=%h exp=0f0f", cpu_data_in); end
  endtask

  task automatic test_reset_during_read;
    int st, t0;
    @(negedge clk); ack_delay = 0; cpu_addr = 16'h0030;
    @(negedge clk); #1;
    checks++; if (bif.bus_req !== 1'b1 || bif.bus_addr !== 16'h0030) begin failures++; $display("FAIL rdr_req got=%0h/%h exp=1/0030", bif.bus_req, bif.bus_addr); end
    reset = 1'b0;
    @(negedge clk); #1;
    checks++; if (bif.bus_req !== 1'b0 || cpu_enable !== 1'b0 || cpu_data_in !== 16'h0000) begin
      failures++; $display("FAIL rdr_abort got=%0h/%0h/%h exp=0/0/0000", bif.bus_req, cpu_enable, cpu_data_in); end
    reset = 1'b1; ack_delay = 1; slave_rdata = 16'h4321; t0 = txn;
    run_until_enable(st);
    checks++; if (st != 2 || cpu_data_in !== 16'h4321) begin failures++; $display("FAIL rdr_reread got=%0d/%h exp=2/4321", st, cpu_data_in); end
    checks++; if (last_addr !== 16'h0030 || txn != t0 + 1) begin failures++; $display("FAIL rdr_addr got=%h/%0d exp=0030/%0d", last_addr, txn, t0 + 1); end
  endtask

`ifdef REFLET_BRIDGE_TIMEOUT_EN
  task automatic test_timeout;
    logic exp_err, exp_en;
    @(negedge clk); ack_delay = 0; cpu_addr = 16'h0040;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp_err = (i == 5) ? 1'b1 : 1'b0;
      exp_en  = (i >= 5) ? 1'b1 : 1'b0;
      checks++; if (bif.bus_error !== exp_err || cpu_enable !== exp_en) begin
        failures++; $display("FAIL to_cyc%0d got=%0h/%0h exp=%0h/%0h", i, bif.bus_error, cpu_enable, exp_err, exp_en); end
    end
    checks++; if (cpu_data_in !== 16'h0000) begin failures++; $display("FAIL to_data got=%h exp=0000", cpu_data_in); end
    ack_delay = 1;
  endtask
`endif

  initial begin
    test_reset;
    test_read_miss;
    test_hit_miss;
    test_write_hit;
    test_write_miss;
    test_slow_ack;
    test_reset_during_read;
`ifdef REFLET_BRIDGE_TIMEOUT_EN
    test_timeout;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
